// File: rtl/i2c_responder.sv
// I2C target exposing a 2^MEM_AW-byte register file; define I2C_RSP_GLITCH_FILTER_EN for a 3-sample input filter.
// Latency: 2-clk pin sync (+2 with filter), registered outputs; no backpressure, fully paced by the bus master.
module i2c_responder #(
  parameter logic [6:0] I2C_ADDR = 7'h22,
  parameter int         MEM_AW   = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              scl_i,
  input  logic              sda_i,
  output logic              sda_oe_o,
  output logic              busy_o,
  output logic              wr_stb_o,
  output logic [MEM_AW-1:0] wr_addr_o,
  output logic [7:0]        wr_data_o
);

  localparam int DEPTH = 2**MEM_AW;

  typedef enum logic [3:0] {
    IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, WAIT_P
  } state_t;

  logic [1:0] scl_sync, sda_sync;
  logic       scl, sda;
  logic       scl_q, sda_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_sync <= 2'b11;
      sda_sync <= 2'b11;
    end else begin
      scl_sync <= {scl_sync[0], scl_i};
      sda_sync <= {sda_sync[0], sda_i};
    end
  end

`ifdef I2C_RSP_GLITCH_FILTER_EN
  // Output follows the synchronizer only once three successive samples agree.
  logic [1:0] scl_hist, sda_hist;
  logic       scl_hold, sda_hold;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_hist <= 2'b11;
      sda_hist <= 2'b11;
      scl_hold <= 1'b1;
      sda_hold <= 1'b1;
    end else begin
      scl_hist <= {scl_hist[0], scl_sync[1]};
      sda_hist <= {sda_hist[0], sda_sync[1]};
      scl_hold <= scl;
      sda_hold <= sda;
    end
  end

  assign scl = (scl_sync[1] == scl_hist[0] && scl_hist[0] == scl_hist[1]) ? scl_sync[1] : scl_hold;
  assign sda = (sda_sync[1] == sda_hist[0] && sda_hist[0] == sda_hist[1]) ? sda_sync[1] : sda_hold;
`else
  assign scl = scl_sync[1];
  assign sda = sda_sync[1];
`endif

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      scl_q <= 1'b1;
      sda_q <= 1'b1;
    end else begin
      scl_q <= scl;
      sda_q <= sda;
    end
  end

  logic scl_rise, scl_fall, start_det, stop_det;
  assign scl_rise  = scl & ~scl_q;
  assign scl_fall  = ~scl & scl_q;
  assign start_det = scl & scl_q & sda_q & ~sda;
  assign stop_det  = scl & scl_q & ~sda_q & sda;

  state_t            state;
  logic [2:0]        cnt;
  logic [7:0]        shift;
  logic              rw;
  logic              ack_on;
  logic [MEM_AW-1:0] ptr;
  logic [7:0]        mem [DEPTH];
  logic [7:0]        rx_byte;

  assign rx_byte = {shift[6:0], sda};

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= IDLE;
      cnt       <= 3'd0;
      shift     <= 8'h00;
      rw        <= 1'b0;
      ack_on    <= 1'b0;
      ptr       <= '0;
      sda_oe_o  <= 1'b0;
      busy_o    <= 1'b0;
      wr_stb_o  <= 1'b0;
      wr_addr_o <= '0;
      wr_data_o <= 8'h00;
      for (int i = 0; i < DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      wr_stb_o <= 1'b0;
      if (start_det) begin
        state    <= ADDR;
        cnt      <= 3'd0;
        ack_on   <= 1'b0;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b1;
      end else if (stop_det) begin
        state    <= IDLE;
        ack_on   <= 1'b0;
        sda_oe_o <= 1'b0;
        busy_o   <= 1'b0;
      end else begin
        case (state)
          ADDR: if (scl_rise) begin
            shift <= rx_byte;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              if (rx_byte[7:1] == I2C_ADDR) begin
                rw    <= rx_byte[0];
                state <= ADDR_ACK;
              end else begin
                state <= IDLE;
              end
            end
          end
          // First fall drives the ACK low, the second fall ends the ACK slot.
          ADDR_ACK, PTR_ACK, WACK: if (scl_fall) begin
            if (!ack_on) begin
              sda_oe_o <= 1'b1;
              ack_on   <= 1'b1;
            end else begin
              ack_on <= 1'b0;
              cnt    <= 3'd0;
              if (state == ADDR_ACK && rw) begin
                shift    <= mem[ptr];
                sda_oe_o <= ~mem[ptr][7];
                state    <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= (state == ADDR_ACK) ? PTR : WDATA;
              end
            end
          end
          PTR: if (scl_rise) begin
            shift <= rx_byte;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              ptr   <= rx_byte[MEM_AW-1:0];
              state <= PTR_ACK;
            end
          end
          WDATA: if (scl_rise) begin
            shift <= rx_byte;
            cnt   <= cnt + 3'd1;
            if (cnt == 3'd7) begin
              mem[ptr]  <= rx_byte;
              wr_stb_o  <= 1'b1;
              wr_addr_o <= ptr;
              wr_data_o <= rx_byte;
              ptr       <= ptr + 1'b1;
              state     <= WACK;
            end
          end
          RDATA: begin
            if (scl_rise) begin
              cnt <= cnt + 3'd1;
              if (cnt == 3'd7) state <= RACK;
            end else if (scl_fall) begin
              shift    <= {shift[6:0], 1'b0};
              sda_oe_o <= ~shift[6];
            end
          end
          // ack_on here records that the master ACKed and the next byte is due.
          RACK: begin
            if (scl_rise) begin
              if (!sda) begin
                ptr    <= ptr + 1'b1;
                ack_on <= 1'b1;
              end else begin
                sda_oe_o <= 1'b0;
                state    <= WAIT_P;
              end
            end else if (scl_fall) begin
              if (ack_on) begin
                ack_on   <= 1'b0;
                cnt      <= 3'd0;
                shift    <= mem[ptr];
                sda_oe_o <= ~mem[ptr][7];
                state    <= RDATA;
              end else begin
                sda_oe_o <= 1'b0;
              end
            end
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_i2c_responder.sv
// Directed bench for i2c_responder: bit-banged open-drain master, scoreboards for writes and reads.
module tb_i2c_responder;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       scl_m = 1'b1;
  logic       sda_m = 1'b1;
  logic       sda_oe, busy, wr_stb;
  logic [3:0] wr_addr;
  logic [7:0] wr_data;
  wire        sda_line = sda_m & ~sda_oe;

  always #5 clk = ~clk;

  i2c_responder #(.I2C_ADDR(7'h22), .MEM_AW(4)) dut (
    .clk_i(clk), .rst_i(rst), .scl_i(scl_m), .sda_i(sda_line),
    .sda_oe_o(sda_oe), .busy_o(busy), .wr_stb_o(wr_stb),
    .wr_addr_o(wr_addr), .wr_data_o(wr_data)
  );

`ifdef I2C_RSP_GLITCH_FILTER_EN
  localparam logic GLITCH_SEEN = 1'b0;
`else
  localparam logic GLITCH_SEEN = 1'b1;
`endif

  int total = 0, passed = 0, failed = 0;
  logic [15:0] wr_q[$];
  logic [7:0]  rd_q[$];
  int busy_cycles = 0, oe_cycles = 0, stb_count = 0;
  logic [15:0] wr_exp;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (busy === 1'b1) busy_cycles++;
    if (sda_oe === 1'b1) oe_cycles++;
    if (wr_stb === 1'b1) begin
      stb_count++;
      check("wr_expected", (wr_q.size() != 0), 1);
      if (wr_q.size() != 0) begin
        wr_exp = wr_q.pop_front();
        check("wr_addr", wr_addr, wr_exp[11:8]);
        check("wr_data", wr_data, wr_exp[7:0]);
      end
    end
  end

  task automatic wt();
    repeat (10) @(posedge clk);
    #1;
  endtask

  task automatic i2c_start();
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b0; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic i2c_stop();
    sda_m = 1'b0; wt();
    scl_m = 1'b1; wt();
    sda_m = 1'b1; wt();
  endtask

  task automatic send_bit(input logic b);
    sda_m = b;    wt();
    scl_m = 1'b1; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic write_byte(input logic [7:0] b, input logic exp_ack, input string tag);
    logic ack;
    for (int i = 7; i >= 0; i--) send_bit(b[i]);
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    ack = sda_line;
    scl_m = 1'b0; wt();
    check(tag, ack, exp_ack);
  endtask

  task automatic read_byte(input logic mack, output logic [7:0] d);
    d = 8'h00;
    for (int i = 7; i >= 0; i--) begin
      sda_m = 1'b1; wt();
      scl_m = 1'b1; wt();
      d[i] = sda_line;
      scl_m = 1'b0; wt();
    end
    sda_m = mack; wt();
    scl_m = 1'b1; wt();
    scl_m = 1'b0; wt();
  endtask

  task automatic read_check(input logic mack, input logic [7:0] exp, input string tag);
    logic [7:0] d;
    rd_q.push_back(exp);
    read_byte(mack, d);
    check(tag, d, rd_q.pop_front());
  endtask

  initial begin
    int oe0, stb0, busy0;
    logic b;

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_oe", sda_oe, 0);
    check("rst_busy", busy, 0);
    check("rst_stb", wr_stb, 0);
    check("rst_addr", wr_addr, 0);
    check("rst_data", wr_data, 0);
    rst = 1'b0;
    wt();

    // Write 0xA5, 0x5A starting at pointer 3
    i2c_start();
    check("busy_after_start", busy, 1);
    write_byte(8'h44, 1'b0, "w_addr_ack");
    write_byte(8'h03, 1'b0, "w_ptr_ack");
    wr_q.push_back({8'h03, 8'hA5});
    write_byte(8'hA5, 1'b0, "w_d0_ack");
    wr_q.push_back({8'h04, 8'h5A});
    write_byte(8'h5A, 1'b0, "w_d1_ack");
    i2c_stop();
    check("busy_after_stop", busy, 0);
    check("w_all_stored", wr_q.size(), 0);

    // Set pointer, repeated START, read back with ACK then NACK
    i2c_start();
    write_byte(8'h44, 1'b0, "r_waddr_ack");
    write_byte(8'h03, 1'b0, "r_ptr_ack");
    i2c_start();
    write_byte(8'h45, 1'b0, "r_raddr_ack");
    read_check(1'b0, 8'hA5, "r_byte0");
    read_check(1'b1, 8'h5A, "r_byte1");
    check("r_oe_after_nack", sda_oe, 0);
    i2c_stop();
    check("r_busy_after_stop", busy, 0);

    // Wrong address: no ACK, no drive, no store
    oe0 = oe_cycles;
    stb0 = stb_count;
    i2c_start();
    write_byte(8'h46, 1'b1, "nm_addr_nack");
    write_byte(8'h00, 1'b1, "nm_data_nack");
    i2c_stop();
    check("nm_oe_quiet", oe_cycles - oe0, 0);
    check("nm_no_stb", stb_count - stb0, 0);

    // Pointer wraps from 0xF to 0x0
    i2c_start();
    write_byte(8'h44, 1'b0, "wrap_addr_ack");
    write_byte(8'h0F, 1'b0, "wrap_ptr_ack");
    wr_q.push_back({8'h0F, 8'h11});
    write_byte(8'h11, 1'b0, "wrap_d0_ack");
    wr_q.push_back({8'h00, 8'h22});
    write_byte(8'h22, 1'b0, "wrap_d1_ack");
    wr_q.push_back({8'h01, 8'h33});
    write_byte(8'h33, 1'b0, "wrap_d2_ack");
    i2c_stop();
    check("wrap_all_stored", wr_q.size(), 0);

    // Reset in the middle of a read while SDA is being pulled low
    i2c_start();
    write_byte(8'h44, 1'b0, "mr_waddr_ack");
    write_byte(8'h03, 1'b0, "mr_ptr_ack");
    i2c_start();
    write_byte(8'h45, 1'b0, "mr_raddr_ack");
    sda_m = 1'b1; wt();
    scl_m = 1'b1; wt();
    b = sda_line;
    scl_m = 1'b0; wt();
    check("mr_bit7", b, 1);
    check("mr_oe_before_rst", sda_oe, 1);
    rst = 1'b1;
    #1;
    check("mr_oe_in_rst", sda_oe, 0);
    check("mr_busy_in_rst", busy, 0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    scl_m = 1'b1; wt();
    check("mr_busy_after_rst", busy, 0);
    i2c_start();
    write_byte(8'h44, 1'b0, "mr2_waddr_ack");
    write_byte(8'h03, 1'b0, "mr2_ptr_ack");
    i2c_start();
    write_byte(8'h45, 1'b0, "mr2_raddr_ack");
    read_check(1'b1, 8'h00, "mr2_cleared");
    i2c_stop();

    // One-clock SDA glitch while SCL is high
    scl_m = 1'b1;
    sda_m = 1'b1;
    wt();
    busy0 = busy_cycles;
    @(posedge clk); #1;
    sda_m = 1'b0;
    @(posedge clk); #1;
    sda_m = 1'b1;
    wt();
    wt();
    check("glitch_start_seen", (busy_cycles != busy0), GLITCH_SEEN);
    check("glitch_busy_after", busy, 0);

    check("final_wr_q_empty", wr_q.size(), 0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/i2c_responder.md
I2C_RESPONDER -- requirements
Module: i2c_responder

Interface
REQ-001 SHALL have parameter I2C_ADDR, default 7'h22: the 7-bit responder address.
REQ-002 SHALL have parameter MEM_AW, default 4: the byte-memory address width (2^MEM_AW bytes).
REQ-003 SHALL have port clk_i, input, 1: the single clock; all logic SHALL be in this domain.
REQ-004 SHALL have port rst_i, input, 1: reset, asynchronous and active-high.
REQ-005 SHALL have port scl_i, input, 1: the I2C SCL pin, asynchronous.
REQ-006 SHALL have port sda_i, input, 1: the I2C SDA pin, asynchronous.
REQ-007 SHALL have port sda_oe_o, output, 1: 1 pulls SDA low, 0 releases it; the output is registered.
REQ-008 SHALL have port busy_o, output, 1: high from a detected START until a detected STOP.
REQ-009 SHALL have port wr_stb_o, output, 1: a one-cycle pulse for each data byte stored in memory.
REQ-010 SHALL have port wr_addr_o, output, MEM_AW: the memory address of the stored byte, valid with wr_stb_o.
REQ-011 SHALL have port wr_data_o, output, 8: the stored byte, valid with wr_stb_o.

Function
REQ-012 SHALL pass scl_i and sda_i through 2-flop synchronizers; all edges SHALL be detected on the synchronized values.
REQ-013 SHALL detect START as an SDA fall while SCL is high, and STOP as an SDA rise while SCL is high.
REQ-014 START/STOP detection SHALL take precedence over bit sampling in the same cycle.
REQ-015 SHALL use FSM states IDLE, ADDR, ADDR_ACK, PTR, PTR_ACK, WDATA, WACK, RDATA, RACK, WAIT_P.
REQ-016 SHALL sample bits MSB first on SCL rising edges, with a 3-bit bit counter.
REQ-017 After the 8th address bit, if bits[7:1]==I2C_ADDR, sda_oe_o SHALL go 1 one clk after the next SCL fall and go 0 one clk after the following SCL fall.
REQ-018 On an address mismatch, the block SHALL go to IDLE with no ACK and ignore the bus until the next START.
REQ-019 When R/W=0, the first data byte SHALL load the pointer with its low MEM_AW bits; the byte SHALL be ACKed and SHALL NOT be stored.
REQ-020 When R/W=0, each subsequent byte SHALL be ACKed and stored to mem[ptr], with wr_stb_o/wr_addr_o/wr_data_o pulsed one clk after the 8th rising edge; ptr SHALL then increment modulo 2^MEM_AW.
REQ-021 When R/W=1, the block SHALL load mem[ptr] into the shift register on the SCL fall that ends the address ACK.
REQ-022 When R/W=1, it SHALL drive sda_oe_o = ~bit on each SCL fall for 8 bits, release SDA for the 9th bit and sample the master ACK on the 9th rise.
REQ-023 On master ACK (0), ptr SHALL increment and the next byte SHALL be sent; on NACK (1), the block SHALL go to WAIT_P with SDA released.
REQ-024 A repeated START in any state SHALL go to ADDR, clear the bit counter, retain ptr, and set sda_oe_o to 0 next clk.
REQ-025 A STOP in any state SHALL go to IDLE, set sda_oe_o to 0, and clear busy_o next clk.
REQ-026 ptr and memory contents SHALL persist across transactions.

Reset
REQ-027 rst_i high SHALL immediately force sda_oe_o=0, busy_o=0, wr_stb_o=0, wr_addr_o=0, wr_data_o=0, ptr=0, all memory bytes=8'h00, state=IDLE, synchronizers=1.
REQ-028 A reset asserted mid-transfer SHALL abort it; after release the block SHALL require a fresh START.

Configuration
REQ-029 With I2C_RSP_GLITCH_FILTER_EN defined, each synchronized input SHALL update only after 3 consecutive equal samples, adding 2 clk latency.
REQ-030 Without I2C_RSP_GLITCH_FILTER_EN, the 2-flop synchronizer output SHALL be used directly.

Verification
REQ-031 SHALL cover: START, 0x44, 0x03, 0xA5, 0x5A, STOP -> 4 ACKs; wr_stb_o twice, (addr 3, 0xA5) then (addr 4, 0x5A); busy_o 0 after STOP.
REQ-032 SHALL cover: START, 0x44, 0x03, repeated START, 0x45, master ACK then NACK -> read data 0xA5, 0x5A; sda_oe_o 0 after NACK.
REQ-033 SHALL cover: START, 0x46, 0x00, STOP -> sda_oe_o stays 0 and no wr_stb_o pulse.
REQ-034 SHALL cover: ptr 0x0F, write 0x11, 0x22, 0x33 -> wr_addr_o sequence F, 0, 1.
REQ-035 SHALL cover: rst_i pulsed while sda_oe_o=1 during a read -> sda_oe_o 0 in the same cycle; a subsequent read of addr 3 returns 0x00.
REQ-036 SHALL cover: a 1-clk SDA low glitch while SCL high -> START detected without I2C_RSP_GLITCH_FILTER_EN, ignored with it.
